input_debouncer: RTL and testbench

//   Conditions one raw, asynchronous, bouncy input bit before it reaches the gate-level logic (notGate and peers).

---
 rtl/input_debouncer_pkg.sv | 18 +
 rtl/sync_2ff.sv | 24 ++
 rtl/input_debouncer.sv | 131 +++++++++++++
 tb/tb_input_debouncer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: filter state encodings and the
// default debounce depth.
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'b00,
        S_TO_HIGH = 2'b01,
        S_HIGH    = 2'b11,
        S_TO_LOW  = 2'b10
    } state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces one raw asynchronous input: 2-flop sync followed by a counting
// filter FSM producing a registered level and one-cycle rise/fall pulses.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic c,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_depth
        $error("input_debouncer: DEBOUNCE_CYCLES must be >= 2");
    end

    logic s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             c_q,     c_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic             busy_q,  busy_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (a),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // Pulses default low so each lasts exactly one cycle after an accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_TO_HIGH;
                    cnt_d   = CNT_ONE;
                    busy_d  = 1'b1;
                end
            end

            S_TO_HIGH: begin
                if (!s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    c_d     = 1'b1;
                    rise_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_HIGH: begin
                if (!s) begin
                    state_d = S_TO_LOW;
                    cnt_d   = CNT_ONE;
                    busy_d  = 1'b1;
                end
            end

            S_TO_LOW: begin
                if (s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    fall_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
                c_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign c    = c_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer with DEBOUNCE_CYCLES=4: expected
// rise/fall events are queued by the stimulus and matched by a monitor.
module tb_input_debouncer;

    logic clk;
    logic rst_n;
    logic a;
    logic c;
    logic rise;
    logic fall;
    logic busy;

    typedef struct {
        bit          is_rise;
        int unsigned cyc;
    } ev_t;

    ev_t         sb[$];
    int unsigned cyc;
    int          checks;
    int          errors;

    input_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .c     (c),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First edge sampling the new value is cyc+1; accept lands 5 edges later.
    task automatic expect_event(input bit is_rise);
        ev_t e;
        e.is_rise = is_rise;
        e.cyc     = cyc + 6;
        sb.push_back(e);
    endtask

    task automatic step(input logic val);
        @(negedge clk);
        a = val;
        expect_event(val);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("busy_window", int'(busy), (i >= 3 && i <= 5) ? 1 : 0);
        end
        repeat (4) @(negedge clk);
        chk("level_after_step", int'(c), int'(val));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: got none expected %s at cycle %0d (now %0d)",
                         sb[0].is_rise ? "rise" : "fall", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (rise || fall) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got rise=%0d fall=%0d expected none (cycle %0d)",
                             rise, fall, cyc);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("event_kind_rise", int'(rise), int'(e.is_rise));
                    chk("event_cycle", int'(cyc), int'(e.cyc));
                    chk("c_at_event", int'(c), int'(rise));
                end
            end
            chk("rise_fall_exclusive", int'(rise && fall), 0);
            chk("pulse_while_busy", int'(busy && (rise || fall)), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bv[6];
        bit saw_busy;
        bit found;
        bv = '{1, 0, 1, 1, 0, 1};
        checks = 0;
        errors = 0;

        rst_n = 1'b0;
        a     = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_c", int'(c), 0);
        chk("reset_rise", int'(rise), 0);
        chk("reset_fall", int'(fall), 0);
        chk("reset_busy", int'(busy), 0);

        // Release with a already high: first sampling edge follows release.
        rst_n = 1'b1;
        expect_event(1'b1);
        repeat (12) @(negedge clk);
        chk("level_after_reset_release", int'(c), 1);

        step(1'b0);
        step(1'b1);
        step(1'b0);

        // Two-cycle glitch must be rejected.
        saw_busy = 1'b0;
        @(negedge clk);
        a = 1'b1;
        repeat (2) @(negedge clk);
        a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        chk("glitch_busy_seen", int'(saw_busy), 1);
        chk("glitch_c_low", int'(c), 0);
        chk("glitch_busy_idle", int'(busy), 0);

        // Bounce then settle high: one rise timed from the final stable 1.
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            a = bv[j][0];
            if (j == 5) expect_event(1'b1);
        end
        repeat (12) @(negedge clk);
        chk("bounce_c_high", int'(c), 1);

        step(1'b0);

        // Reset while counting toward high: candidate discarded immediately.
        @(negedge clk);
        a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (busy) found = 1'b1;
        end
        chk("midcount_busy_reached", int'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("midcount_c", int'(c), 0);
        chk("midcount_busy", int'(busy), 0);
        chk("midcount_rise", int'(rise), 0);
        a = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("after_midcount_c", int'(c), 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
